// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage. Decodes the MEM control bus, performs
//               byte/half/word loads and stores on an internal data memory,
//               registers the extended load result toward MEM/WB and offers
//               a stall-time debug read port. All state changes on the
//               falling clock edge.
//               Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned
//               accesses are suppressed and flagged; otherwise the offset is
//               silently forced to natural alignment).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int NB_DATA     = 32,
    parameter int NB_MEM_CTRL = 6,
    parameter int MEM_DEPTH   = 256,
    parameter int NB_MEM_ADDR = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_pipe_i,
    input  logic [NB_DATA-1:0]     alu_result_i,
    input  logic [NB_DATA-1:0]     data_write_i,
    input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
    output logic [NB_DATA-1:0]     read_data_o,
    input  logic [NB_MEM_ADDR-1:0] debug_addr_i,
    input  logic                   debug_rd_req_i,
    output logic [NB_DATA-1:0]     debug_rd_data_o,
    output logic                   debug_rd_valid_o,
    output logic                   misaligned_o
);

    localparam int c_LANES = NB_DATA / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_RESP    = 2'd2
    } dbg_state_t;

    logic [NB_DATA-1:0]     r_mem [MEM_DEPTH];
    logic [NB_DATA-1:0]     r_read_data;
    logic                   r_misaligned;
    dbg_state_t             r_dbg_state;
    logic [NB_MEM_ADDR-1:0] r_dbg_addr;
    logic [NB_DATA-1:0]     r_dbg_data;
    logic                   r_dbg_valid;

    logic                   w_mem_read;
    logic                   w_mem_write;
    logic                   w_unsigned;
    logic                   w_is_byte;
    logic                   w_is_half;
    logic                   w_is_word;
    logic [NB_MEM_ADDR-1:0] w_word_idx;
    logic [1:0]             w_raw_off;
    logic [1:0]             w_off;
    logic                   w_misaligned;
    logic [NB_DATA-1:0]     w_old_word;
    logic [NB_DATA-1:0]     w_shifted;
    logic [NB_DATA-1:0]     w_load_data;
    logic [c_LANES-1:0]     w_byte_en;
    logic [NB_DATA-1:0]     w_wr_lanes;
    logic [NB_DATA-1:0]     w_new_word;
    logic                   w_unused_bits;

    assign w_mem_read  = MEM_control_i[5];
    assign w_mem_write = MEM_control_i[4];
    assign w_unsigned  = MEM_control_i[3];
    // Size 10 is not a legal encoding and is handled as a word access.
    assign w_is_byte   = (MEM_control_i[1:0] == 2'b00);
    assign w_is_half   = (MEM_control_i[1:0] == 2'b01);
    assign w_is_word   = MEM_control_i[1];

    // Upper address bits are ignored so addresses wrap around the memory.
    assign w_word_idx  = alu_result_i[NB_MEM_ADDR+1:2];
    assign w_raw_off   = alu_result_i[1:0];
    assign w_unused_bits = ^{alu_result_i[NB_DATA-1:NB_MEM_ADDR+2], MEM_control_i[2]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_off        = w_raw_off;
    assign w_misaligned = (w_mem_read | w_mem_write) &
                          ((w_is_half & w_raw_off[0]) | (w_is_word & (w_raw_off != 2'b00)));
`else
    assign w_off        = w_is_word ? 2'b00 :
                          w_is_half ? {w_raw_off[1], 1'b0} : w_raw_off;
    assign w_misaligned = 1'b0;
`endif

    assign w_old_word = r_mem[w_word_idx];
    assign w_shifted  = w_old_word >> {w_off, 3'b000};

    // Right-justify the selected lane(s) and extend to full width.
    always_comb begin
        w_load_data = '0;
        if (w_is_byte) begin
            w_load_data = {{(NB_DATA-8){~w_unsigned & w_shifted[7]}}, w_shifted[7:0]};
        end else if (w_is_half) begin
            w_load_data = {{(NB_DATA-16){~w_unsigned & w_shifted[15]}}, w_shifted[15:0]};
        end else begin
            w_load_data = w_old_word;
        end
    end

    // Lane enables and lane-replicated store data for the merge below.
    always_comb begin
        w_byte_en  = '1;
        w_wr_lanes = data_write_i;
        if (w_is_byte) begin
            w_byte_en  = c_LANES'(1) << w_off;
            w_wr_lanes = {c_LANES{data_write_i[7:0]}};
        end else if (w_is_half) begin
            w_byte_en  = c_LANES'(3) << w_off;
            w_wr_lanes = {(c_LANES/2){data_write_i[15:0]}};
        end
    end

    generate
        for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
            assign w_new_word[gi*8 +: 8] = w_byte_en[gi] ? w_wr_lanes[gi*8 +: 8]
                                                         : w_old_word[gi*8 +: 8];
        end
    endgenerate

    // Data memory write port; contents survive reset.
    always_ff @(negedge clock_i) begin
        if (enable_pipe_i && w_mem_write && !w_misaligned) begin
            r_mem[w_word_idx] <= w_new_word;
        end
    end

    // Load result register and sticky misalignment flag.
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
        end else if (enable_pipe_i) begin
            if (w_mem_read && !w_misaligned) begin
                r_read_data <= w_load_data;
            end else begin
                r_read_data <= '0;
            end
            if (w_misaligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    // Debug read FSM: data and valid are loaded on entry to RESP, which only
    // happens while the pipeline is frozen, so memory is stable at capture.
    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            r_dbg_state <= S_IDLE;
            r_dbg_addr  <= '0;
            r_dbg_data  <= '0;
            r_dbg_valid <= 1'b0;
        end else begin
            r_dbg_valid <= 1'b0;
            case (r_dbg_state)
                S_IDLE: begin
                    if (debug_rd_req_i) begin
                        r_dbg_addr <= debug_addr_i;
                        if (!enable_pipe_i) begin
                            r_dbg_state <= S_RESP;
                            r_dbg_data  <= r_mem[debug_addr_i];
                            r_dbg_valid <= 1'b1;
                        end else begin
                            r_dbg_state <= S_PENDING;
                        end
                    end
                end
                S_PENDING: begin
                    if (!enable_pipe_i) begin
                        r_dbg_state <= S_RESP;
                        r_dbg_data  <= r_mem[r_dbg_addr];
                        r_dbg_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_dbg_state <= S_IDLE;
                end
                default: begin
                    r_dbg_state <= S_IDLE;
                end
            endcase
        end
    end

    assign read_data_o      = r_read_data;
    assign misaligned_o     = r_misaligned;
    assign debug_rd_data_o  = r_dbg_data;
    assign debug_rd_valid_o = r_dbg_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. A byte-array
//               reference model tracks memory, load results and the sticky
//               misalignment flag; debug reads are checked against it.
//               Honours DMEM_ALIGN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [5:0]  ctrl;
    logic [31:0] rdata;
    logic [7:0]  daddr;
    logic        dreq;
    logic [31:0] ddata;
    logic        dvalid;
    logic        mis;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  m [0:1023];
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          pulses;
    logic [31:0] last_ddata;

    mem_access_stage dut (
        .clock_i         (clk),
        .reset_i         (rst),
        .enable_pipe_i   (en),
        .alu_result_i    (alu),
        .data_write_i    (wdata),
        .MEM_control_i   (ctrl),
        .read_data_o     (rdata),
        .debug_addr_i    (daddr),
        .debug_rd_req_i  (dreq),
        .debug_rd_data_o (ddata),
        .debug_rd_valid_o(dvalid),
        .misaligned_o    (mis)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mword(input int a);
        int b;
        b = a & 1020;
        return {m[b+3], m[b+2], m[b+1], m[b]};
    endfunction

    // One falling-edge step: drive, update the model, clock, check.
    task automatic acc(input bit e, input bit rd, input bit wr, input bit uns,
                       input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
        int a, nb;
        bit mi;
        logic [31:0] val;
        en = e; alu = addr; wdata = data;
        ctrl = {rd, wr, uns, 1'b0, sz};
        a  = int'(addr[9:0]);
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mi = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mi = (rd || wr) && ((a % nb) != 0);
`else
        a  = a - (a % nb);
`endif
        if (rst) begin
            exp_rd  = '0;
            exp_mis = 1'b0;
        end else if (e) begin
            val = '0;
            for (int k = 0; k < nb; k++) val |= 32'(m[(a + k) & 1023]) << (8 * k);
            if (nb == 1 && !uns && val[7])  val |= 32'hFFFF_FF00;
            if (nb == 2 && !uns && val[15]) val |= 32'hFFFF_0000;
            exp_rd = (rd && !mi) ? val : 32'h0;
            if (wr && !mi)
                for (int k = 0; k < nb; k++) m[(a + k) & 1023] = data[8*k +: 8];
            if (mi) exp_mis = 1'b1;
        end
        @(negedge clk);
        #1;
        if (dvalid === 1'b1) begin
            pulses++;
            last_ddata = ddata;
        end
        check({tag, "_rd"}, rdata, exp_rd);
        check({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_mis});
    endtask

    task automatic nop(input bit e);
        acc(e, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0, "nop");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; alu = '0; wdata = '0; ctrl = '0;
        daddr = '0; dreq = 1'b0;
        exp_rd = '0; exp_mis = 1'b0; pulses = 0; last_ddata = '0;
        @(negedge clk); @(negedge clk); #1;
        check("rst_rd", rdata, 32'h0);
        check("rst_dd", ddata, 32'h0);
        check("rst_dv", {31'b0, dvalid}, 32'h0);
        check("rst_mis", {31'b0, mis}, 32'h0);
        rst = 1'b0;

        // Give every word in the exercised range a known value.
        for (int i = 0; i < 64; i++)
            acc(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'(i * 4), $urandom, "init");

        // Directed loads and stores.
        acc(1, 0, 1, 0, 2'b11, 32'h10, 32'h8765_4321, "sw10");
        acc(1, 1, 0, 0, 2'b11, 32'h10, 32'h0, "lw10");
        check("tp_lw", rdata, 32'h8765_4321);
        acc(1, 1, 0, 0, 2'b00, 32'h13, 32'h0, "lb13");
        check("tp_lb", rdata, 32'hFFFF_FF87);
        acc(1, 1, 0, 1, 2'b00, 32'h13, 32'h0, "lbu13");
        check("tp_lbu", rdata, 32'h0000_0087);
        acc(1, 1, 0, 0, 2'b01, 32'h12, 32'h0, "lh12");
        check("tp_lh", rdata, 32'hFFFF_8765);
        acc(1, 0, 1, 0, 2'b00, 32'h11, 32'h0000_00AB, "sb11");
        acc(1, 1, 0, 0, 2'b11, 32'h10, 32'h0, "lw10b");
        check("tp_sb", rdata, 32'h8765_AB21);
        acc(0, 1, 1, 0, 2'b11, 32'h10, 32'h1111_1111, "hold");
        check("tp_hold", rdata, 32'h8765_AB21);
        acc(1, 1, 1, 0, 2'b11, 32'h10, 32'h2222_2222, "rbw");
        check("tp_rbw", rdata, 32'h8765_AB21);
        acc(1, 1, 0, 0, 2'b11, 32'h410, 32'h0, "wrap");
        check("tp_wrap", rdata, 32'h2222_2222);
        acc(1, 0, 0, 0, 2'b11, 32'h10, 32'h0, "noread");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ad;
            ad = $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) ad = ad + 32'h400 * $urandom_range(1, 7);
            acc($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), ad, $urandom, "rnd");
        end

        // Debug request while running: held in PENDING, second request ignored.
        pulses = 0;
        dreq = 1'b1; daddr = 8'd4; nop(1'b1);
        daddr = 8'd9; nop(1'b1);
        dreq = 1'b0; nop(1'b1);
        nop(1'b0);
        check("dbg_pend_valid", {31'b0, dvalid}, 32'h1);
        check("dbg_pend_data", ddata, mword(16));
        nop(1'b0); nop(1'b0); nop(1'b0);
        check("dbg_pend_count", 32'(pulses), 32'd1);

        // Request while frozen responds on the next edge; request in RESP ignored.
        pulses = 0;
        dreq = 1'b1; daddr = 8'd7; nop(1'b0);
        check("dbg_imm_data", last_ddata, mword(28));
        daddr = 8'd2; nop(1'b0);
        dreq = 1'b0; nop(1'b0); nop(1'b0);
        check("dbg_imm_count", 32'(pulses), 32'd1);
        check("dbg_hold_data", ddata, mword(28));

        // Reset while PENDING abandons the request.
        pulses = 0;
        dreq = 1'b1; daddr = 8'd5; nop(1'b1);
        dreq = 1'b0; rst = 1'b1; nop(1'b1);
        rst = 1'b0;
        check("dbg_rst_data", ddata, 32'h0);
        nop(1'b0); nop(1'b0); nop(1'b0);
        check("dbg_rst_count", 32'(pulses), 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
        acc(1, 0, 1, 0, 2'b11, 32'h22, 32'hDEAD_BEEF, "sw22");
        check("al_flag", {31'b0, mis}, 32'h1);
        acc(1, 1, 0, 0, 2'b11, 32'h20, 32'h0, "lw20");
        check("al_unchanged", rdata, mword(32));
        acc(1, 1, 0, 0, 2'b01, 32'h21, 32'h0, "lh21");
        check("al_ld_zero", rdata, 32'h0);
        check("al_sticky", {31'b0, mis}, 32'h1);
        rst = 1'b1; nop(1'b1); rst = 1'b0;
        check("al_rst_mis", {31'b0, mis}, 32'h0);
        check("al_rst_rd", rdata, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
